// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with a valid/ready request side and a valid/ready
// result side. Single-cycle ops finish in one cycle. Optional iterative
// MUL/DIVU/REMU datapath is enabled by defining SEQ_ALU_MULDIV_EN.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1 (valid_i/ready_o on the request side, valid_o/ready_i on the result
// side). A producer holds its payload stable while valid is high and ready is low.
module seq_alu #(
  parameter int XLen    = 32,
  parameter int OpWidth = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [XLen-1:0]    a_i,
  input  logic [XLen-1:0]    b_i,
  input  logic [OpWidth-1:0] op_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [XLen-1:0]    result_o,
  output logic               zero_o,
  output logic               illegal_o,
  output logic [1:0]         state_o
);

  localparam int ShW = $clog2(XLen);

  localparam logic [OpWidth-1:0] OpAdd  = OpWidth'(0);
  localparam logic [OpWidth-1:0] OpSub  = OpWidth'(1);
  localparam logic [OpWidth-1:0] OpAnd  = OpWidth'(2);
  localparam logic [OpWidth-1:0] OpOr   = OpWidth'(3);
  localparam logic [OpWidth-1:0] OpXor  = OpWidth'(4);
  localparam logic [OpWidth-1:0] OpSlt  = OpWidth'(5);
  localparam logic [OpWidth-1:0] OpSltu = OpWidth'(6);
  localparam logic [OpWidth-1:0] OpSll  = OpWidth'(7);
  localparam logic [OpWidth-1:0] OpSrl  = OpWidth'(8);
  localparam logic [OpWidth-1:0] OpSra  = OpWidth'(9);
`ifdef SEQ_ALU_MULDIV_EN
  localparam logic [OpWidth-1:0] OpMul  = OpWidth'(10);
  localparam logic [OpWidth-1:0] OpDivu = OpWidth'(11);
  localparam logic [OpWidth-1:0] OpRemu = OpWidth'(12);
  localparam int CntW = $clog2(XLen) + 1;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [XLen-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic            illegal_q, illegal_d;

  logic [XLen-1:0] alu_res;
  logic            alu_ill;
  logic            is_iter;
  logic            accept;
  logic            slt, sltu;

  assign slt     = $signed(a_i) < $signed(b_i);
  assign sltu    = a_i < b_i;
  assign ready_o = (state_q == IDLE) | ((state_q == DONE) & ready_i);
  assign valid_o = (state_q == DONE);
  assign accept  = valid_i & ready_o;
  assign result_o  = result_q;
  assign zero_o    = zero_q;
  assign illegal_o = illegal_q;
  assign state_o   = state_q;

  // Single-cycle result and op classification from the incoming request.
  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    is_iter = 1'b0;
    case (op_i)
      OpAdd:  alu_res = a_i + b_i;
      OpSub:  alu_res = a_i - b_i;
      OpAnd:  alu_res = a_i & b_i;
      OpOr:   alu_res = a_i | b_i;
      OpXor:  alu_res = a_i ^ b_i;
      OpSlt:  alu_res = {{(XLen-1){1'b0}}, slt};
      OpSltu: alu_res = {{(XLen-1){1'b0}}, sltu};
      OpSll:  alu_res = a_i << b_i[ShW-1:0];
      OpSrl:  alu_res = a_i >> b_i[ShW-1:0];
      OpSra:  alu_res = $unsigned($signed(a_i) >>> b_i[ShW-1:0]);
`ifdef SEQ_ALU_MULDIV_EN
      OpMul, OpDivu, OpRemu: is_iter = 1'b1;
`endif
      default: alu_ill = 1'b1;
    endcase
  end

`ifdef SEQ_ALU_MULDIV_EN
  // a_q: multiplicand (MUL) or dividend/quotient shift register (DIV).
  // b_q: multiplier (MUL) or divisor (DIV). acc_q: product or remainder.
  logic [XLen-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            mul_q, mul_d, rem_q, rem_d;
  logic [XLen:0]   rem_shift, rem_sub;
  logic            iter_last;

  assign rem_shift = {acc_q, a_q[XLen-1]};
  assign rem_sub   = rem_shift - {1'b0, b_q};
  assign iter_last = (cnt_q == CntW'(XLen));

  // Operand load on accept, then one shift-add or restoring-divide step per cycle.
  // A zero divisor naturally yields an all-ones quotient and remainder = dividend.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    mul_d = mul_q;
    rem_d = rem_q;
    if (state_q != BUSY && accept && is_iter) begin
      a_d   = a_i;
      b_d   = b_i;
      acc_d = '0;
      cnt_d = '0;
      mul_d = (op_i == OpMul);
      rem_d = (op_i == OpRemu);
    end else if (state_q == BUSY && !iter_last) begin
      cnt_d = cnt_q + 1'b1;
      if (mul_q) begin
        acc_d = acc_q + (b_q[0] ? a_q : '0);
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
      end else begin
        a_d   = {a_q[XLen-2:0], ~rem_sub[XLen]};
        acc_d = rem_sub[XLen] ? rem_shift[XLen-1:0] : rem_sub[XLen-1:0];
      end
    end
  end

  // Iteration registers; cleared by reset so an aborted op leaves nothing behind.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      mul_q <= 1'b0;
      rem_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      mul_q <= mul_d;
      rem_q <= rem_d;
    end
  end
`endif

  // Next-state and result capture; result fields change only when entering DONE.
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          if (is_iter) begin
            state_d = BUSY;
          end else begin
            state_d   = DONE;
            result_d  = alu_res;
            zero_d    = (alu_res == '0);
            illegal_d = alu_ill;
          end
        end else if (state_q == DONE && ready_i) begin
          state_d = IDLE;
        end
      end
      BUSY: begin
`ifdef SEQ_ALU_MULDIV_EN
        if (iter_last) begin
          state_d   = DONE;
          result_d  = (mul_q | rem_q) ? acc_q : a_q;
          zero_d    = ((mul_q | rem_q) ? acc_q : a_q) == '0;
          illegal_d = 1'b0;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      result_q  <= '0;
      zero_q    <= 1'b1;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter XLen, default 32, datapath width in bits; legal values are even and at least 8.
REQ-002 Parameter OpWidth, default 4, width of op_i.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  reset, asynchronous and active-high.
REQ-005 valid_i  input  1  request valid.
REQ-006 ready_o  output  1  block accepts a request this cycle.
REQ-007 a_i  input  XLen  operand A.
REQ-008 b_i  input  XLen  operand B.
REQ-009 op_i  input  OpWidth  operation select.
REQ-010 valid_o  output  1  result valid.
REQ-011 ready_i  input  1  consumer accepts the result.
REQ-012 result_o  output  XLen  registered result.
REQ-013 zero_o  output  1  set when result_o equals 0.
REQ-014 illegal_o  output  1  set when the op was unsupported; result_o is then 0.

Function
REQ-015 Op encodings:
- 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
- 5 SLT (signed), 6 SLTU; both produce 1 or 0.
- 7 SLL, 8 SRL, 9 SRA, shift amount b_i[$clog2(XLen)-1:0].
- 10 MUL (low XLen bits of the product), 11 DIVU, 12 REMU.
- Any other encoding is illegal.
REQ-016 A request is accepted on a cycle where valid_i and ready_o are both 1; the operands and op are captured on that edge.
REQ-017 The FSM has three states: IDLE, BUSY and DONE. Transitions:
- IDLE -> DONE when a single-cycle op or an illegal op is accepted.
- IDLE -> BUSY when MUL, DIVU or REMU is accepted.
- BUSY -> DONE after exactly XLen iteration cycles.
- DONE -> IDLE when ready_i is 1 and no new request is accepted.
- DONE -> DONE or BUSY when ready_i is 1 and a new request is accepted on the same cycle.
REQ-018 valid_o is 1 only in DONE.
REQ-019 ready_o = (state==IDLE) | (state==DONE & ready_i). This gives single-cycle ops a throughput of one result per cycle.
REQ-020 Latency from accept to valid_o:
- single-cycle and illegal ops: 1 cycle.
- MUL, DIVU, REMU: XLen+1 cycles.
REQ-021 MUL is an iterative shift-add, one multiplier bit per cycle.
REQ-022 DIVU and REMU are restoring division, one quotient bit per cycle.
REQ-023 Division by zero: DIVU returns all-ones and REMU returns a_i. It takes the same XLen+1 cycle latency and illegal_o stays 0.
REQ-024 All arithmetic wraps modulo 2^XLen; overflow is not flagged.
REQ-025 result_o, zero_o and illegal_o are stable while valid_o=1 and ready_i=0 (backpressure). They update only when a new result enters DONE.
REQ-026 In BUSY, ready_o is 0 and valid_i is ignored.
REQ-027 zero_o is computed from the final registered result and applies to every op, including illegal ops.

Reset
REQ-028 Asserting rst_i forces the following immediately, asynchronously and in any state (including mid-iteration in BUSY):
- state to IDLE, ready_o to 1, valid_o to 0.
- result_o to 0, zero_o to 1, illegal_o to 0.
- internal iteration counter and partial registers to 0.
REQ-029 An operation in flight at reset is discarded and produces no result.

Configuration
REQ-030 The MUL/DIV datapath is controlled by the macro SEQ_ALU_MULDIV_EN.
- Defined: ops 10-12 behave as in REQ-015 to REQ-023.
- Not defined: ops 10-12 are illegal (1-cycle latency, result_o=0, illegal_o=1), BUSY is unreachable, and no iteration logic is synthesised.

Verification
REQ-031 Reset mid-BUSY: rst_i pulse while a MUL is in BUSY -> same cycle valid_o=0, ready_o=1, result_o=0, zero_o=1; the next accepted ADD 1+1 returns 2.
REQ-032 Back-to-back ADD with ready_i=1: valid_i held for 3 cycles with ADD 5+7, SUB 3-5, SLT -1<1 -> results 12, 0xFFFFFFFE, 1 on 3 consecutive cycles.
REQ-033 MUL with SEQ_ALU_MULDIV_EN defined: 0xFFFF x 0x10001 -> 0xFFFFFFFF exactly 33 cycles after accept; ready_o=0 for cycles 1-32.
REQ-034 Division: DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 9/0 -> 0xFFFFFFFF; REMU 9/0 -> 9; illegal_o=0 throughout.
REQ-035 Backpressure: ready_i=0 for 5 cycles after AND 0xF0&0x0F -> result_o=0 and zero_o=1 held, ready_o=0; ready_i=1 -> transfer then IDLE.
REQ-036 Illegal op: op 15, and op 10 without SEQ_ALU_MULDIV_EN -> 1 cycle later valid_o=1, illegal_o=1, result_o=0, zero_o=1.
